// File: rtl/dmux4way_dispatcher.sv
// dmux4way_dispatcher: single-word skid dispatcher that routes a 16-bit
// upstream stream to one of four valid/ready sinks, either in strict
// round-robin rotation or to a fixed channel. Target select is decoded
// through a DMux4Way primitive.

// dmux4way: 1-to-4 demultiplexer, routes 'in' to the output picked by sel.
module dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  // Route the input to exactly one output; the others stay low.
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    case (sel)
      2'd0:    a = in;
      2'd1:    b = in;
      2'd2:    c = in;
      default: d = in;
    endcase
  end

endmodule

module dmux4way_dispatcher (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        mode,
  input  logic [1:0]  fixed_sel,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  sel,
  output logic [7:0]  sent_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic [15:0] data_q;
  logic [1:0]  rr_ptr;
  logic        held_mode;   // mode of the word currently held

  logic        holding;
  logic        xfer;
  logic        accept;
  logic [1:0]  next_ptr;
  logic [1:0]  target;

  // Handshake decode: transfer, accept and the target of a new word.
  // next_ptr is the pointer after any transfer this cycle, so a word accepted
  // alongside a round-robin transfer goes to the following channel.
  always_comb begin
    holding  = (state == HOLD);
    xfer     = holding && out_ready[sel];
    in_ready = !holding || out_ready[sel];
    accept   = in_valid && in_ready;
    next_ptr = (xfer && !held_mode) ? sel + 2'd1 : rr_ptr;
    target   = mode ? fixed_sel : next_ptr;
  end

  // State, data, target and counter update; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      held_mode <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      if (xfer) begin
        sent_cnt <= sent_cnt + 8'd1;
        rr_ptr   <= next_ptr;
      end
      if (accept) begin
        state     <= HOLD;
        data_q    <= in_data;
        sel       <= target;
        held_mode <= mode;
      end else if (xfer) begin
        state <= IDLE;
      end
    end
  end

  assign out_data = data_q;

  dmux4way u_dmux (
    .in  (holding),
    .sel (sel),
    .a   (out_valid[0]),
    .b   (out_valid[1]),
    .c   (out_valid[2]),
    .d   (out_valid[3])
  );

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Directed bench for dmux4way_dispatcher. Inputs change 1ns after each rising
// edge; outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_dmux4way_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        mode;
  logic [1:0]  fixed_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [1:0]  sel;
  logic [7:0]  sent_cnt;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [1:0]  exp_rr  = 2'd0;
  logic [3:0]  exp_ov;

  dmux4way_dispatcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .fixed_sel (fixed_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA;
    mode = 1'b0; fixed_sel = 2'd0; out_ready = 4'b1111;
    tick; tick;
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
    tests_run++;
    if (sent_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_sent_cnt got %0d want 0", sent_cnt); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_data !== 16'h0000 || sel !== 2'd0) begin tests_failed++; $display("FAIL reset_data_sel got %h/%0d want 0000/0", out_data, sel); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_no_accept got %b want 0000", out_valid); end
  endtask

  task test_rr_stream;
    logic [15:0] words [5];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
    words[3] = 16'h0044; words[4] = 16'h0055;
    mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = words[i];
      tick;
      exp_ov = 4'b0001 << (i % 4);
      tests_run++;
      if (out_valid !== exp_ov || out_data !== words[i] || in_ready !== 1'b1)
        begin tests_failed++; $display("FAIL rr_stream[%0d] got ov=%b d=%h rdy=%b want ov=%b d=%h rdy=1", i, out_valid, out_data, in_ready, exp_ov, words[i]); end
    end
    in_valid = 1'b0;
    tick;
    exp_cnt = 8'd5; exp_rr = 2'd1;
    tests_run++;
    if (sent_cnt !== exp_cnt || out_valid !== 4'b0000) begin tests_failed++; $display("FAIL rr_stream_cnt got cnt=%0d ov=%b want cnt=5 ov=0000", sent_cnt, out_valid); end
  endtask

  task test_stall;
    // dummy word to channel 1 moves the pointer to 2
    mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'h0101;
    tick;
    in_valid = 1'b0;
    tick;
    exp_cnt++; exp_rr = 2'd2;
    out_ready = 4'b1011; in_valid = 1'b1; in_data = 16'hBEEF;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (out_valid !== 4'b0100 || out_data !== 16'hBEEF || in_ready !== 1'b0)
        begin tests_failed++; $display("FAIL stall[%0d] got ov=%b d=%h rdy=%b want ov=0100 d=beef rdy=0", i, out_valid, out_data, in_ready); end
      tick;
    end
    tests_run++;
    if (sent_cnt !== exp_cnt) begin tests_failed++; $display("FAIL stall_cnt got %0d want %0d", sent_cnt, exp_cnt); end
    out_ready = 4'b1111;
    tick;
    exp_cnt++; exp_rr = 2'd3;
    tests_run++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || sent_cnt !== exp_cnt)
      begin tests_failed++; $display("FAIL stall_release got ov=%b rdy=%b cnt=%0d want 0000/1/%0d", out_valid, in_ready, sent_cnt, exp_cnt); end
    // probe pointer: next round-robin word must go to channel 3
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 16'h0303;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (sel !== 2'd3 || out_valid !== 4'b1000) begin tests_failed++; $display("FAIL stall_rr_ptr got sel=%0d ov=%b want 3/1000", sel, out_valid); end
    out_ready = 4'b1111;
    tick;
    exp_cnt++; exp_rr = 2'd0;
  endtask

  task test_fixed;
    // one round-robin word to channel 0 leaves the pointer at 1
    mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'h0A0A;
    tick;
    in_valid = 1'b0;
    tick;
    exp_cnt++; exp_rr = 2'd1;
    mode = 1'b1; fixed_sel = 2'd3; out_ready = 4'b0000; in_valid = 1'b1; in_data = 16'h1234;
    tick;
    in_valid = 1'b0; fixed_sel = 2'd0; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 4'b1000 || sel !== 2'd3 || out_data !== 16'h1234)
        begin tests_failed++; $display("FAIL fixed_hold[%0d] got ov=%b sel=%0d d=%h want 1000/3/1234", i, out_valid, sel, out_data); end
      tick;
    end
    out_ready = 4'b1000;
    tick;
    exp_cnt++;
    tests_run++;
    if (out_valid !== 4'b0000 || sent_cnt !== exp_cnt) begin tests_failed++; $display("FAIL fixed_xfer got ov=%b cnt=%0d want 0000/%0d", out_valid, sent_cnt, exp_cnt); end
    out_ready = 4'b0000; mode = 1'b0; in_valid = 1'b1; in_data = 16'h0B0B;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (sel !== exp_rr || out_valid !== 4'b0010) begin tests_failed++; $display("FAIL fixed_rr_unchanged got sel=%0d ov=%b want %0d/0010", sel, out_valid, exp_rr); end
    out_ready = 4'b1111;
    tick;
    exp_cnt++; exp_rr = 2'd2;
  endtask

  task test_wrap;
    int unsigned n;
    n = 256 - int'(exp_cnt);
    mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_data = 16'(k);
      tick;
    end
    tests_run++;
    if (sent_cnt !== 8'd255) begin tests_failed++; $display("FAIL wrap_255 got %0d want 255", sent_cnt); end
    in_valid = 1'b0;
    tick;
    exp_cnt = 8'd0;
    exp_rr = 2'(exp_rr + 2'(n));
    tests_run++;
    if (sent_cnt !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero got %0d want 0", sent_cnt); end
  endtask

  task test_reset_mid;
    mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1; in_data = 16'hC0DE;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (sel !== exp_rr || out_valid === 4'b0000) begin tests_failed++; $display("FAIL mid_hold got sel=%0d ov=%b want sel=%0d nonzero", sel, out_valid, exp_rr); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 4'b0000 || sent_cnt !== 8'd0 || out_data !== 16'h0000)
      begin tests_failed++; $display("FAIL mid_reset got ov=%b cnt=%0d d=%h want 0000/0/0000", out_valid, sent_cnt, out_data); end
    in_valid = 1'b1; in_data = 16'h0D0D;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (sel !== 2'd0 || out_valid !== 4'b0001) begin tests_failed++; $display("FAIL mid_rr_ptr got sel=%0d ov=%b want 0/0001", sel, out_valid); end
  endtask

  initial begin
    test_reset;
    test_rr_stream;
    test_stall;
    test_fixed;
    test_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
